// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding and default frame geometry.
package uart_pkg;
   localparam int DEF_DATA_BITS   = 8;
   localparam int DEF_SAMPLE_RATE = 16;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous single-bit input.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic d_in,
   output logic q_out
);
   logic r_meta, r_q;
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_meta <= RESET_VAL;
         r_q    <= RESET_VAL;
      end else begin
         r_meta <= d_in;
         r_q    <= r_meta;
      end
   end
   assign q_out = r_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled 8N1-style receiver with a one-entry valid/ready output buffer.
// Frame errors and overruns are reported as single-cycle pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_BITS   = DEF_DATA_BITS,
   parameter int SAMPLE_RATE = DEF_SAMPLE_RATE
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 tick_in,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 valid_out,
   input  logic                 ready_in,
   output logic                 frame_err_out,
   output logic                 overrun_out
);
   localparam int CW = $clog2(SAMPLE_RATE);
   localparam int IW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] MID      = CW'(SAMPLE_RATE / 2 - 1);
   localparam logic [CW-1:0] LAST     = CW'(SAMPLE_RATE - 1);
   localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

   rx_state_t            r_state;
   logic [CW-1:0]        r_cnt;
   logic [IW-1:0]        r_idx;
   logic [DATA_BITS-1:0] r_shift, r_data;
   logic                 r_valid, r_ferr, r_ovr;
   logic                 w_rx_s, w_xfer;

   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .d_in  (rx_in),
      .q_out (w_rx_s)
   );

   assign w_xfer = r_valid & ready_in;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_ferr <= 1'b0;
         r_ovr  <= 1'b0;
         if (w_xfer) r_valid <= 1'b0;
         if (tick_in) begin
            case (r_state)
               IDLE:
                  if (!w_rx_s) begin
                     r_state <= START;
                     r_cnt   <= '0;
                  end
               START:
                  if (r_cnt == MID) begin
                     r_state <= w_rx_s ? IDLE : DATA;
                     r_cnt   <= '0;
                     r_idx   <= '0;
                  end else r_cnt <= r_cnt + CW'(1);
               DATA:
                  if (r_cnt == LAST) begin
                     r_shift <= DATA_BITS'({w_rx_s, r_shift} >> 1);
                     r_cnt   <= '0;
                     r_idx   <= r_idx + IW'(1);
                     if (r_idx == LAST_BIT) r_state <= STOP;
                  end else r_cnt <= r_cnt + CW'(1);
               STOP:
                  if (r_cnt == LAST) begin
                     r_state <= IDLE;
                     r_cnt   <= '0;
                     // a pending byte survives unless it is being taken on this same edge
                     if (!w_rx_s) r_ferr <= 1'b1;
                     else if (r_valid && !ready_in) r_ovr <= 1'b1;
                     else begin
                        r_data  <= r_shift;
                        r_valid <= 1'b1;
                     end
                  end else r_cnt <= r_cnt + CW'(1);
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign data_out      = r_data;
   assign valid_out     = r_valid;
   assign frame_err_out = r_ferr;
   assign overrun_out   = r_ovr;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: frame-level stimulus with a byte-queue reference model for uart_rx.
module tb_uart_rx;
   localparam int DB = 8;
   localparam int SR = 16;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_rx;
      int         exp_ferr;
   } vec_t;

   logic          clk_in = 1'b0;
   logic          rst_in, tick_in, rx_in, ready_in;
   logic [DB-1:0] data_out;
   logic          valid_out, frame_err_out, overrun_out;

   uart_rx #(.DATA_BITS(DB), .SAMPLE_RATE(SR)) dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .tick_in      (tick_in),
      .rx_in        (rx_in),
      .data_out     (data_out),
      .valid_out    (valid_out),
      .ready_in     (ready_in),
      .frame_err_out(frame_err_out),
      .overrun_out  (overrun_out)
   );

   always #5 clk_in = ~clk_in;

   int total = 0, bad = 0;
   int tper = 4, tcnt = 0, edge_cnt = 0, f_t0 = 0;
   logic [7:0] rx_q[$];
   int n_ferr, n_ovr, n_long, n_unstable, max_vrun, vrun, n_rise, rise_tick, rise_prev_tick;
   logic p_valid = 0, p_ready = 0, p_tick = 0, p_ferr = 0, p_ovr = 0;
   logic [7:0] p_data = 0;

   initial begin
      tick_in = 1'b0;
      forever begin
         @(posedge clk_in);
         #1;
         tcnt = tcnt + 1;
         if (tcnt >= tper) begin
            tcnt = 0;
            tick_in = 1'b1;
         end else tick_in = 1'b0;
      end
   end

   // edge_cnt counts tick edges up to and including the most recent rising edge
   always @(negedge clk_in) begin
      if (!rst_in) begin
         if (valid_out && ready_in) rx_q.push_back(data_out);
         if (frame_err_out) begin n_ferr++; if (p_ferr) n_long++; end
         if (overrun_out) begin n_ovr++; if (p_ovr) n_long++; end
         if (p_valid && !p_ready && (!valid_out || data_out != p_data)) n_unstable++;
         vrun = valid_out ? vrun + 1 : 0;
         if (vrun > max_vrun) max_vrun = vrun;
         if (valid_out && !p_valid) begin
            n_rise++;
            rise_tick = edge_cnt - f_t0;
            rise_prev_tick = int'(p_tick);
         end
      end
      p_valid = valid_out; p_ready = ready_in; p_tick = tick_in;
      p_ferr = frame_err_out; p_ovr = overrun_out; p_data = data_out;
      if (tick_in) edge_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_tick();
      @(negedge clk_in);
      while (!tick_in) @(negedge clk_in);
      @(posedge clk_in);
      #2;
   endtask

   task automatic clear();
      rx_q.delete();
      n_ferr = 0; n_ovr = 0; n_long = 0; n_unstable = 0;
      max_vrun = 0; vrun = 0; n_rise = 0; rise_tick = -1; rise_prev_tick = -1;
   endtask

   // rdy raises ready_in for exactly the cycle whose edge samples the stop bit
   task automatic send_frame(input logic [7:0] d, input logic stop, input bit rdy);
      wait_tick();
      f_t0 = edge_cnt;
      rx_in = 1'b0;
      repeat (SR) wait_tick();
      for (int i = 0; i < DB; i++) begin
         rx_in = d[i];
         repeat (SR) wait_tick();
      end
      rx_in = stop;
      if (rdy) begin
         repeat (SR / 2) wait_tick();
         do begin @(posedge clk_in); #2; end while (!tick_in);
         ready_in = 1'b1;
         @(posedge clk_in);
         #2;
         ready_in = 1'b0;
         repeat (SR / 2 - 1) wait_tick();
      end else repeat (SR) wait_tick();
      rx_in = 1'b1;
      repeat (8) wait_tick();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[6];
      logic [7:0] exp_q[$];
      int exp_ferr;
      logic [7:0] d;
      logic s;
      vecs[0] = '{8'hA5, 1'b1, 1, 0};
      vecs[1] = '{8'h00, 1'b1, 1, 0};
      vecs[2] = '{8'hFF, 1'b1, 1, 0};
      vecs[3] = '{8'h3C, 1'b0, 0, 1};
      vecs[4] = '{8'h81, 1'b1, 1, 0};
      vecs[5] = '{8'h5A, 1'b0, 0, 1};
      rst_in = 1'b1; rx_in = 1'b1; ready_in = 1'b1;
      clear();
      repeat (3) @(posedge clk_in);
      #2;
      chk("rst_valid", valid_out, 0);
      chk("rst_data", data_out, 0);
      chk("rst_ferr", frame_err_out, 0);
      chk("rst_ovr", overrun_out, 0);
      rst_in = 1'b0;

      // single frame at the production tick rate, checking output timing
      tper = 54;
      clear();
      send_frame(8'hA5, 1'b1, 1'b0);
      chk("a5_count", rx_q.size(), 1);
      chk("a5_data", rx_q[0], 8'hA5);
      chk("a5_width", max_vrun, 1);
      chk("a5_after_tick", rise_prev_tick, 1);
      chk("a5_stop_mid", (rise_tick >= 148 && rise_tick <= 156), 1);
      chk("a5_errs", n_ferr + n_ovr, 0);
      tper = 4;

      // short low glitch is rejected
      clear();
      wait_tick();
      rx_in = 1'b0;
      repeat (4) wait_tick();
      rx_in = 1'b1;
      repeat (20) wait_tick();
      chk("glitch_valid", n_rise, 0);
      chk("glitch_ferr", n_ferr, 0);
      chk("glitch_ovr", n_ovr, 0);

      foreach (vecs[i]) begin
         clear();
         send_frame(vecs[i].data, vecs[i].stop, 1'b0);
         chk($sformatf("vec%0d_count", i), rx_q.size(), vecs[i].exp_rx);
         if (vecs[i].exp_rx > 0) chk($sformatf("vec%0d_data", i), rx_q[0], vecs[i].data);
         chk($sformatf("vec%0d_ferr", i), n_ferr, vecs[i].exp_ferr);
         chk($sformatf("vec%0d_ovr", i), n_ovr, 0);
         chk($sformatf("vec%0d_pulse", i), n_long, 0);
      end

      // overrun: second byte dropped while the first is held
      clear();
      ready_in = 1'b0;
      send_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0);
      chk("ovr_hold_data", data_out, 8'h11);
      chk("ovr_hold_valid", valid_out, 1);
      chk("ovr_count", n_ovr, 1);
      chk("ovr_pulse", n_long, 0);
      chk("ovr_stable", n_unstable, 0);
      ready_in = 1'b1;
      repeat (3) @(posedge clk_in);
      #2;
      chk("ovr_xfer_count", rx_q.size(), 1);
      chk("ovr_xfer_data", rx_q[0], 8'h11);
      chk("ovr_valid_drop", valid_out, 0);

      // transfer on the completion edge loads the new byte without overrun
      clear();
      ready_in = 1'b0;
      send_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b1);
      chk("coin_xfer_count", rx_q.size(), 1);
      chk("coin_xfer_data", rx_q[0], 8'h11);
      chk("coin_valid", valid_out, 1);
      chk("coin_data", data_out, 8'h22);
      chk("coin_ovr", n_ovr, 0);
      chk("coin_stable", n_unstable, 0);

      // reset during bit 3 with a byte still pending
      wait_tick();
      rx_in = 1'b0;
      repeat (SR) wait_tick();
      for (int i = 0; i < 3; i++) begin
         rx_in = i[0];
         repeat (SR) wait_tick();
      end
      rx_in = 1'b1;
      repeat (SR / 2) wait_tick();
      @(negedge clk_in);
      rst_in = 1'b1;
      #1;
      chk("mid_rst_valid", valid_out, 0);
      chk("mid_rst_data", data_out, 0);
      chk("mid_rst_ferr", frame_err_out, 0);
      chk("mid_rst_ovr", overrun_out, 0);
      ready_in = 1'b1;
      repeat (3) @(negedge clk_in);
      rst_in = 1'b0;
      clear();
      repeat (20) wait_tick();
      chk("post_rst_idle", n_rise, 0);
      send_frame(8'h5A, 1'b1, 1'b0);
      chk("post_rst_count", rx_q.size(), 1);
      chk("post_rst_data", rx_q[0], 8'h5A);
      chk("post_rst_ferr", n_ferr, 0);

      // random frames against the byte-queue model
      clear();
      exp_ferr = 0;
      for (int n = 0; n < 8; n++) begin
         tper = $urandom_range(3, 6);
         d = 8'($urandom);
         s = ($urandom_range(0, 3) != 0);
         send_frame(d, s, 1'b0);
         if (s) exp_q.push_back(d);
         else exp_ferr++;
      end
      chk("rand_count", rx_q.size(), exp_q.size());
      foreach (exp_q[i]) chk($sformatf("rand_data%0d", i), (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      chk("rand_ferr", n_ferr, exp_ferr);
      chk("rand_ovr", n_ovr, 0);
      chk("rand_pulse", n_long, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
